matmul_fp_tile_sched: RTL and testbench

MATMUL_FP_TILE_SCHED -- requirements
Module: matmul_fp_tile_sched

---
 rtl/matmul_sched_pkg.sv | 8 +
 rtl/matmul_fp_tile_sched_if.sv | 27 ++
 rtl/sched_delay_line.sv | 39 +++
 rtl/matmul_fp_tile_sched.sv | 89 ++++++++
 tb/tb_matmul_fp_tile_sched.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/matmul_sched_pkg.sv
// matmul_sched_pkg: scheduler FSM state type and default parameter values shared by the tile scheduler files
package matmul_sched_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int ADDR_W_DEF = 16;
  localparam int DP_LATENCY_DEF = 4;
  localparam int CREDITS_DEF = 4;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/matmul_fp_tile_sched_if.sv
// matmul_fp_tile_sched_if: job control in (start/counts/abort/pop), issue/address/write/status out; slave = scheduler, master = driver
interface matmul_fp_tile_sched_if import matmul_sched_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic i_start;
  logic i_abort;
  logic i_c_pop;
  logic [CNT_W-1:0] i_row_tiles;
  logic [CNT_W-1:0] i_col_tiles;
  logic o_issue;
  logic o_c_we;
  logic o_busy;
  logic o_done;
  logic o_err;
  logic [CNT_W-1:0] o_a_addr;
  logic [CNT_W-1:0] o_b_addr;
  logic [ADDR_W-1:0] o_c_addr;
  modport slave (
    input i_start, i_row_tiles, i_col_tiles, i_abort, i_c_pop,
    output o_issue, o_a_addr, o_b_addr, o_c_we, o_c_addr, o_busy, o_done, o_err
  );
  modport master (
    output i_start, i_row_tiles, i_col_tiles, i_abort, i_c_pop,
    input o_issue, o_a_addr, o_b_addr, o_c_we, o_c_addr, o_busy, o_done, o_err
  );
endinterface

// File: rtl/sched_delay_line.sv
// sched_delay_line: DEPTH-deep valid+address shift register (i_valid/i_addr in, o_valid/o_addr out DEPTH cycles later, o_pend = entries still behind the output stage)
module sched_delay_line #(
  parameter int DEPTH = 4,
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_addr,
  output logic         o_valid,
  output logic [W-1:0] o_addr,
  output logic         o_pend
);
  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0][W-1:0] a_q, a_d;
  always_comb begin
    v_d = '0;
    a_d = '0;
    o_pend = 1'b0;
    v_d[0] = i_valid;
    a_d[0] = i_addr;
    for (int k = 1; k < DEPTH; k++) begin
      v_d[k] = v_q[k-1];
      a_d[k] = a_q[k-1];
      o_pend = o_pend | v_q[k-1];
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v_q <= '0;
      a_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
    end
  end
  assign o_valid = v_q[DEPTH-1];
  assign o_addr = a_q[DEPTH-1];
endmodule

// File: rtl/matmul_fp_tile_sched.sv
// matmul_fp_tile_sched: row-major A/B tile issue scheduler with result-slot credits; ports i_clk, i_rst_n (async, low) and bus (slave modport: job control in, issue/write/status out)
module matmul_fp_tile_sched import matmul_sched_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DP_LATENCY = DP_LATENCY_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input logic i_clk,
  input logic i_rst_n,
  matmul_fp_tile_sched_if.slave bus
);
  localparam int CR_W = $clog2(CREDITS + 1);
  state_e state_q, state_d;
  logic pend_q, pend_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] rows_q, rows_d, cols_q, cols_d, row_q, row_d, col_q, col_d;
  logic [CR_W-1:0] cred_q, cred_d;
  logic issue, last_col, full, dl_pend, c_we;
  logic [ADDR_W-1:0] issue_addr, c_addr;
  always_comb begin
    last_col = col_q == cols_q - 1'b1;
    full = cred_q == CR_W'(CREDITS);
    issue = state_q == S_RUN && cred_q != '0 && !bus.i_abort;
    issue_addr = ADDR_W'(row_q) * ADDR_W'(cols_q) + ADDR_W'(col_q);
    state_d = state_q;
    pend_d = pend_q;
    rows_d = rows_q;
    cols_d = cols_q;
    row_d = issue && last_col ? row_q + 1'b1 : row_q;
    col_d = issue ? (last_col ? '0 : col_q + 1'b1) : col_q;
    cred_d = issue && !bus.i_c_pop ? cred_q - 1'b1 : !issue && bus.i_c_pop && !full ? cred_q + 1'b1 : cred_q;
    err_d = err_q || (!issue && bus.i_c_pop && full);
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          state_d = rows_q == '0 || cols_q == '0 ? S_DONE : S_RUN;
        end else if (bus.i_start) begin
          pend_d = 1'b1;
          rows_d = bus.i_row_tiles;
          cols_d = bus.i_col_tiles;
          row_d = '0;
          col_d = '0;
        end
      end
      S_RUN: state_d = bus.i_abort || (issue && last_col && row_q == rows_q - 1'b1) ? S_DRAIN : S_RUN;
      S_DRAIN: state_d = dl_pend ? S_DRAIN : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      pend_q <= 1'b0;
      err_q <= 1'b0;
      rows_q <= '0;
      cols_q <= '0;
      row_q <= '0;
      col_q <= '0;
      cred_q <= CR_W'(CREDITS);
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      err_q <= err_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      row_q <= row_d;
      col_q <= col_d;
      cred_q <= cred_d;
    end
  end
  sched_delay_line #(.DEPTH(DP_LATENCY), .W(ADDR_W)) u_dl (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(issue),
    .i_addr(issue_addr),
    .o_valid(c_we),
    .o_addr(c_addr),
    .o_pend(dl_pend)
  );
  assign bus.o_issue = issue;
  assign bus.o_a_addr = row_q;
  assign bus.o_b_addr = col_q;
  assign bus.o_c_we = c_we;
  assign bus.o_c_addr = c_addr;
  assign bus.o_busy = state_q == S_RUN || state_q == S_DRAIN;
  assign bus.o_done = state_q == S_DONE;
  assign bus.o_err = err_q;
endmodule

// File: tb/tb_matmul_fp_tile_sched.sv
// tb_matmul_fp_tile_sched: directed and randomized jobs checked cycle by cycle against a tile-sequence/credit reference model
module tb_matmul_fp_tile_sched;
  localparam int CNT_W = 8;
  localparam int ADDR_W = 16;
  localparam int LAT = 4;
  localparam int CRED = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int cr = CRED;
  bit err_m = 1'b0;
  int n_early;
  matmul_fp_tile_sched_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();
  matmul_fp_tile_sched #(.CNT_W(CNT_W), .ADDR_W(ADDR_W), .DP_LATENCY(LAT), .CREDITS(CRED)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic credit(input bit iss, input bit pop);
    if (iss && !pop) cr--;
    else if (pop && !iss) begin
      if (cr == CRED) err_m = 1'b1;
      else cr++;
    end
  endtask
  task automatic idle(input int n, input bit pop);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      bus.i_start = 1'b0;
      bus.i_abort = 1'($urandom_range(1));
      bus.i_c_pop = pop;
      @(negedge clk);
      chk("idle_issue", bus.o_issue, 0);
      chk("idle_c_we", bus.o_c_we, 0);
      chk("idle_busy", bus.o_busy, 0);
      chk("idle_done", bus.o_done, 0);
      chk("idle_err", bus.o_err, err_m);
      credit(1'b0, pop);
    end
  endtask
  task automatic job(input int rows, input int cols, input int abort_cyc, input int pop_pct,
                     input logic [63:0] pop_mask, output int early);
    int ntile, k, done_at, last_w;
    bit we_at [512];
    int wa_at [512];
    bit run, ab, iss, pop, fin, drained;
    ntile = rows * cols;
    k = 0;
    last_w = -1;
    early = 0;
    fin = 1'b0;
    drained = 1'b0;
    done_at = ntile == 0 ? 2 : -1;
    for (int c = 0; c < 512; c++) begin
      we_at[c] = 1'b0;
      wa_at[c] = 0;
    end
    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk);
      #1;
      run = ntile > 0 && c >= 2 && !drained;
      ab = c == abort_cyc;
      iss = run && !ab && cr > 0;
      pop = (c < 64 && pop_mask[c]) || (cr < CRED && int'($urandom_range(99)) < pop_pct);
      bus.i_start = c == 0 || c == 1 || (c == 3 && ntile > 0);
      bus.i_row_tiles = c == 0 ? CNT_W'(rows) : CNT_W'($urandom);
      bus.i_col_tiles = c == 0 ? CNT_W'(cols) : CNT_W'($urandom);
      bus.i_abort = ab;
      bus.i_c_pop = pop;
      @(negedge clk);
      chk("issue", bus.o_issue, iss);
      if (iss) begin
        chk("a_addr", bus.o_a_addr, k / cols);
        chk("b_addr", bus.o_b_addr, k % cols);
      end
      chk("c_we", bus.o_c_we, we_at[c]);
      if (we_at[c]) chk("c_addr", bus.o_c_addr, wa_at[c]);
      chk("busy", bus.o_busy, ntile > 0 && c >= 2 && (done_at < 0 || c < done_at));
      chk("done", bus.o_done, c == done_at);
      chk("err", bus.o_err, err_m);
      credit(iss, pop);
      if (iss) begin
        we_at[c + LAT] = 1'b1;
        wa_at[c + LAT] = k;
        last_w = c + LAT;
        k++;
        if (c < 10) early++;
      end
      if (run && (ab || k == ntile)) begin
        drained = 1'b1;
        done_at = last_w + 1 > c + 2 ? last_w + 1 : c + 2;
      end
      fin = done_at >= 0 && c == done_at + 1;
    end
    chk("job_finished", fin, 1);
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_c_pop = 1'b0;
    bus.i_row_tiles = '0;
    bus.i_col_tiles = '0;
    repeat (2) @(negedge clk);
    chk("rst_issue", bus.o_issue, 0);
    chk("rst_c_we", bus.o_c_we, 0);
    chk("rst_c_addr", bus.o_c_addr, 0);
    chk("rst_a_addr", bus.o_a_addr, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    rst_n = 1'b1;
    job(2, 3, -1, 0, 64'h0, n_early);
    job(1, 4, -1, 0, 64'h2400, n_early);
    chk("stall_early_issues", n_early, 2);
    idle(8, 1'b1);
    job(0, 5, -1, 0, 64'h0, n_early);
    job(3, 0, -1, 0, 64'h0, n_early);
    job(3, 3, 6, 0, 64'h0, n_early);
    idle(4, 1'b1);
    job(1, 7, -1, 0, 64'h0, n_early);
    job(1, 3, -1, 0, 64'h1C, n_early);
    chk("pop_issue_same_cycle", n_early, 3);
    idle(7, 1'b1);
    idle(1, 1'b1);
    idle(3, 1'b0);
    job(2, 2, -1, 30, 64'h0, n_early);
    @(posedge clk);
    #1;
    bus.i_start = 1'b1;
    bus.i_row_tiles = 8'd3;
    bus.i_col_tiles = 8'd3;
    bus.i_abort = 1'b0;
    bus.i_c_pop = 1'b0;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_issue", bus.o_issue, 0);
    chk("midrst_c_we", bus.o_c_we, 0);
    chk("midrst_c_addr", bus.o_c_addr, 0);
    chk("midrst_b_addr", bus.o_b_addr, 0);
    chk("midrst_busy", bus.o_busy, 0);
    chk("midrst_err", bus.o_err, 0);
    cr = CRED;
    err_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8, 1'b0);
    job(2, 2, -1, 0, 64'h0, n_early);
    for (int j = 0; j < 8; j++) begin
      job(int'($urandom_range(3)), int'($urandom_range(4)),
          $urandom_range(2) == 0 ? int'($urandom_range(12, 2)) : -1, 40, 64'h0, n_early);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
